// File: rtl/lcg_stream_checker_if.sv
// Sample stream into the LCG checker: valid/data from the source, ready back from the checker.
interface lcg_stream_checker_if;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/lcg_stream_checker.sv
// Locks onto a 16-bit LCG sample stream and flags deviations; all status is registered one cycle after a transfer.
// in_ready drops only in reset and while clear is high; LCG_CHK_STATS_EN adds the saturating match/mismatch counters.
module lcg_stream_checker #(
   parameter int A        = 22697,
   parameter int C        = 1,
   parameter int LOCK_LEN = 4,
   parameter int LOST_LEN = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   lcg_stream_checker_if.slave  stream,
   output logic                 locked,
   output logic                 err_pulse,
   output logic                 err_seen,
   output logic [1:0]           state,
   output logic [15:0]          expected,
   output logic [15:0]          match_cnt,
   output logic [15:0]          mismatch_cnt
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, LOCKED = 2'd2, LOST = 2'd3} state_t;

   localparam logic [3:0] LOCK_L = 4'(LOCK_LEN);
   localparam logic [3:0] LOST_L = 4'(LOST_LEN);

   function automatic logic [15:0] lcg(input logic [15:0] x);
      return 16'(32'(A) * {16'h0000, x} + 32'(C));
   endfunction

   state_t      state_q, state_nxt;
   logic [15:0] exp_q, exp_nxt;
   logic [3:0]  acq_q, acq_nxt, miss_q, miss_nxt;
   logic        rdy_q, pulse_nxt, seen_nxt;
   logic        hit_inc, miss_inc;
   logic        xfer, is_match;
   logic [3:0]  acq_up, miss_up;

   assign stream.in_ready = rdy_q & ~clear;
   assign xfer            = stream.in_valid & stream.in_ready;
   assign is_match        = (stream.in_data == exp_q);
   assign acq_up          = acq_q + 4'd1;
   assign miss_up         = miss_q + 4'd1;

   always_comb begin
      state_nxt = state_q;
      exp_nxt   = exp_q;
      acq_nxt   = acq_q;
      miss_nxt  = miss_q;
      pulse_nxt = 1'b0;
      seen_nxt  = err_seen;
      hit_inc   = 1'b0;
      miss_inc  = 1'b0;
      if (clear) begin
         state_nxt = IDLE;
         exp_nxt   = 16'h0000;
         acq_nxt   = 4'd0;
         miss_nxt  = 4'd0;
         seen_nxt  = 1'b0;
      end else if (xfer) begin
         unique case (state_q)
            IDLE: begin
               exp_nxt   = lcg(stream.in_data);
               acq_nxt   = 4'd0;
               state_nxt = ACQ;
            end
            ACQ: begin
               // Matching or not, the next prediction follows the sample just seen.
               exp_nxt = lcg(stream.in_data);
               if (is_match) begin
                  acq_nxt = acq_up;
                  if (acq_up == LOCK_L) state_nxt = LOCKED;
               end else begin
                  acq_nxt = 4'd0;
               end
            end
            LOCKED: begin
               exp_nxt = lcg(exp_q);
               if (is_match) begin
                  hit_inc = 1'b1;
               end else begin
                  pulse_nxt = 1'b1;
                  seen_nxt  = 1'b1;
                  miss_inc  = 1'b1;
                  miss_nxt  = 4'd1;
                  state_nxt = (LOST_L == 4'd1) ? IDLE : LOST;
               end
            end
            LOST: begin
               exp_nxt = lcg(exp_q);
               if (is_match) begin
                  hit_inc   = 1'b1;
                  miss_nxt  = 4'd0;
                  state_nxt = LOCKED;
               end else begin
                  pulse_nxt = 1'b1;
                  seen_nxt  = 1'b1;
                  miss_inc  = 1'b1;
                  miss_nxt  = miss_up;
                  if (miss_up == LOST_L) state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         exp_q     <= 16'h0000;
         acq_q     <= 4'd0;
         miss_q    <= 4'd0;
         rdy_q     <= 1'b0;
         err_pulse <= 1'b0;
         err_seen  <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         exp_q     <= exp_nxt;
         acq_q     <= acq_nxt;
         miss_q    <= miss_nxt;
         rdy_q     <= 1'b1;
         err_pulse <= pulse_nxt;
         err_seen  <= seen_nxt;
      end
   end

   assign state    = state_q;
   assign expected = exp_q;
   assign locked   = state_q[1];

`ifdef LCG_CHK_STATS_EN
   logic [15:0] hits_q, errs_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hits_q <= 16'h0000;
         errs_q <= 16'h0000;
      end else if (clear) begin
         hits_q <= 16'h0000;
         errs_q <= 16'h0000;
      end else begin
         if (hit_inc && hits_q != 16'hFFFF)  hits_q <= hits_q + 16'd1;
         if (miss_inc && errs_q != 16'hFFFF) errs_q <= errs_q + 16'd1;
      end
   end

   assign match_cnt    = hits_q;
   assign mismatch_cnt = errs_q;
`else
   logic stats_unused;
   assign stats_unused = hit_inc | miss_inc;
   assign match_cnt    = 16'h0000;
   assign mismatch_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lcg_stream_checker.sv
// Random and directed stimulus for lcg_stream_checker against an arithmetic reference model.
module tb_lcg_stream_checker;
   localparam int A        = 22697;
   localparam int C        = 1;
   localparam int LOCK_LEN = 4;
   localparam int LOST_LEN = 3;
`ifdef LCG_CHK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        locked, err_pulse, err_seen;
   logic [1:0]  state;
   logic [15:0] expected, match_cnt, mismatch_cnt;

   lcg_stream_checker_if bus();

   lcg_stream_checker #(.A(A), .C(C), .LOCK_LEN(LOCK_LEN), .LOST_LEN(LOST_LEN)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .stream       (bus),
      .locked       (locked),
      .err_pulse    (err_pulse),
      .err_seen     (err_seen),
      .state        (state),
      .expected     (expected),
      .match_cnt    (match_cnt),
      .mismatch_cnt (mismatch_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int pulse_seen = 0;

   // reference model: mode 0 idle, 1 acquiring, 2 locked, 3 lost
   int m_mode, m_exp, m_acq, m_miss, m_pulse, m_seen, m_hits, m_errs;
   bit m_rdy, m_xfer;
   int src;

   function automatic int f(input int x);
      longint p;
      p = longint'(A) * longint'(x) + longint'(C);
      return int'(p % 65536);
   endfunction

   task automatic chk(input string name, input int act, input int want);
      n_chk++;
      if (act == want) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, want, $time);
   endtask

   task automatic model_reset();
      m_mode = 0; m_exp = 0; m_acq = 0; m_miss = 0; m_pulse = 0;
      m_seen = 0; m_hits = 0; m_errs = 0; m_rdy = 1'b0; m_xfer = 1'b0;
   endtask

   task automatic step();
      int d;
      bit hit;
      m_xfer = 1'b0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      d = int'(bus.in_data);
      m_pulse = 0;
      if (clear) begin
         m_mode = 0; m_exp = 0; m_acq = 0; m_miss = 0;
         m_seen = 0; m_hits = 0; m_errs = 0;
      end else if (bus.in_valid && m_rdy) begin
         m_xfer = 1'b1;
         if (m_mode == 0) begin
            m_exp = f(d); m_acq = 0; m_mode = 1;
         end else if (m_mode == 1) begin
            if (d == m_exp) begin
               m_acq++;
               if (m_acq == LOCK_LEN) m_mode = 2;
            end else m_acq = 0;
            m_exp = f(d);
         end else begin
            hit = (d == m_exp);
            m_exp = f(m_exp);
            if (hit) begin
               if (m_hits < 65535) m_hits++;
               m_miss = 0;
               m_mode = 2;
            end else begin
               m_pulse = 1; m_seen = 1;
               if (m_errs < 65535) m_errs++;
               m_miss = (m_mode == 2) ? 1 : m_miss + 1;
               m_mode = (m_miss >= LOST_LEN) ? 0 : 3;
            end
         end
      end
      m_rdy = 1'b1;
   endtask

   // one full cycle: inputs applied now, model advanced on the edge, returns just after it
   task automatic drive(input bit v, input logic [15:0] d, input bit c);
      bus.in_valid = v;
      bus.in_data  = d;
      clear        = c;
      @(posedge clk);
      step();
      #1;
   endtask

   always @(negedge clk) begin
      chk("state", int'(state), m_mode);
      chk("expected", int'(expected), m_exp);
      chk("locked", int'(locked), (m_mode >= 2) ? 1 : 0);
      chk("err_pulse", int'(err_pulse), m_pulse);
      chk("err_seen", int'(err_seen), m_seen);
      chk("match_cnt", int'(match_cnt), STATS ? m_hits : 0);
      chk("mismatch_cnt", int'(mismatch_cnt), STATS ? m_errs : 0);
      chk("in_ready", int'(bus.in_ready), (rst_n && m_rdy && !clear) ? 1 : 0);
      if (err_pulse) pulse_seen++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = 16'h0000;
      model_reset();
      #1 rst_n = 1'b0;
      drive(0, 16'h0000, 0);
      drive(0, 16'h0000, 0);
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_state", int'(state), 0);
      rst_n = 1'b1;
      drive(0, 16'h0000, 0);
      chk("ready_after_rst", int'(bus.in_ready), 1);

      // seed and lock
      drive(1, 16'h1234, 0);
      chk("seed_state", int'(state), 1);
      chk("seed_expected", int'(expected), 16'hE455);
      src = f(16'h1234);
      for (int i = 0; i < 4; i++) begin
         drive(1, 16'(src), 0);
         src = f(src);
      end
      chk("lock_state", int'(state), 2);
      chk("lock_locked", int'(locked), 1);
      chk("no_pulse_acq", pulse_seen, 0);

      // one wrong sample, then the chain resumes
      drive(1, 16'(src) ^ 16'h00FF, 0);
      src = f(src);
      chk("lost_state", int'(state), 3);
      chk("lost_pulse", int'(err_pulse), 1);
      drive(1, 16'(src), 0);
      src = f(src);
      chk("relock_state", int'(state), 2);
      chk("one_mismatch", int'(mismatch_cnt), STATS ? 1 : 0);
      chk("one_match", int'(match_cnt), STATS ? 1 : 0);
      chk("err_seen_sticky", int'(err_seen), 1);
      chk("one_pulse", pulse_seen, 1);

      // three wrong samples drop lock
      pulse_seen = 0;
      for (int i = 0; i < 3; i++) begin
         drive(1, 16'(src) ^ 16'h8001, 0);
         src = f(src);
         if (i == 0) chk("first_bad_state", int'(state), 3);
      end
      chk("drop_state", int'(state), 0);
      chk("drop_locked", int'(locked), 0);
      drive(0, 16'h0000, 0);
      chk("three_pulses", pulse_seen, 3);
      chk("four_mismatch", int'(mismatch_cnt), STATS ? 4 : 0);

      // clear with a sample offered in the same cycle
      bus.in_valid = 1'b1; bus.in_data = 16'(src); clear = 1'b1;
      #1;
      chk("clear_in_ready", int'(bus.in_ready), 0);
      @(posedge clk);
      step();
      #1;
      chk("clear_state", int'(state), 0);
      chk("clear_err_seen", int'(err_seen), 0);
      chk("clear_mismatch", int'(mismatch_cnt), 0);
      chk("clear_match", int'(match_cnt), 0);

      // lock timing counts transfers, not cycles
      drive(1, 16'h1234, 0);
      src = f(16'h1234);
      for (int i = 0; i < 4; i++) begin
         drive(0, 16'hDEAD, 0);
         drive(0, 16'hBEEF, 0);
         if (i == 3) chk("gap_still_acq", int'(state), 1);
         drive(1, 16'(src), 0);
         src = f(src);
      end
      chk("gap_lock_state", int'(state), 2);

      // randomized stream: valid gaps, injected errors and bursts, sporadic clears
      begin
         int burst;
         burst = 0;
         for (int i = 0; i < 2000; i++) begin
            bit v, c, bad;
            logic [15:0] d;
            if (burst == 0 && $urandom_range(0, 99) == 0) burst = 3;
            v   = ($urandom_range(0, 2) != 0);
            bad = (burst > 0) || ($urandom_range(0, 19) == 0);
            c   = ($urandom_range(0, 79) == 0);
            d   = bad ? (16'(src) ^ 16'($urandom_range(1, 65535))) : 16'(src);
            drive(v, d, c);
            if (m_xfer) begin
               src = f(src);
               if (burst > 0) burst--;
            end
         end
      end

      // asynchronous reset in the middle of a locked stream
      drive(0, 16'h0000, 1);
      drive(1, 16'h1234, 0);
      src = f(16'h1234);
      for (int i = 0; i < 4; i++) begin
         drive(1, 16'(src), 0);
         src = f(src);
      end
      chk("pre_reset_locked", int'(locked), 1);
      bus.in_valid = 1'b1; bus.in_data = 16'(src);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_state", int'(state), 0);
      chk("async_expected", int'(expected), 0);
      chk("async_in_ready", int'(bus.in_ready), 0);
      chk("async_locked", int'(locked), 0);
      drive(1, 16'(src), 0);
      rst_n = 1'b1;
      drive(0, 16'h0000, 0);
      drive(1, 16'h1234, 0);
      chk("reacq_state", int'(state), 1);
      chk("reacq_expected", int'(expected), 16'hE455);
      drive(0, 16'h0000, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
